// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
//   Bundles the three requester ports and the SDRAM controller port of the
//   arbiter.
//   slave  : arbiter side. It takes in the requests, addresses and write data
//            and drives the per-port readies and the controller request.
//   master : environment side (requesters and controller), the mirror image.
//   Signals:
//     p1_req/p1_address/p1_ready                     program cache fill (read)
//     p2_req/p2_wren/p2_address/p2_to_mem/p2_ready   data cache
//     p3_req/p3_wren/p3_address/p3_to_mem/p3_ready   video/aux, narrow address
//     p_offset                                       word index broadcast
//     mem_req/mem_wren/mem_address/mem_to_mem        to the controller
//     mem_ready/mem_offset                           from the controller
interface sdram_port_arbiter_if #(
  parameter int ADDR_W    = 32,
  parameter int P3_ADDR_W = 17,
  parameter int DATA_W    = 16
);
  logic                 p1_req;
  logic [ADDR_W-1:0]    p1_address;
  logic                 p1_ready;
  logic                 p2_req;
  logic                 p2_wren;
  logic [ADDR_W-1:0]    p2_address;
  logic [DATA_W-1:0]    p2_to_mem;
  logic                 p2_ready;
  logic                 p3_req;
  logic                 p3_wren;
  logic [P3_ADDR_W-1:0] p3_address;
  logic [DATA_W-1:0]    p3_to_mem;
  logic                 p3_ready;
  logic [1:0]           p_offset;
  logic                 mem_req;
  logic                 mem_wren;
  logic [ADDR_W-1:0]    mem_address;
  logic [DATA_W-1:0]    mem_to_mem;
  logic                 mem_ready;
  logic [1:0]           mem_offset;

  modport slave (
    input  p1_req, p1_address,
    input  p2_req, p2_wren, p2_address, p2_to_mem,
    input  p3_req, p3_wren, p3_address, p3_to_mem,
    input  mem_ready, mem_offset,
    output p1_ready, p2_ready, p3_ready, p_offset,
    output mem_req, mem_wren, mem_address, mem_to_mem
  );

  modport master (
    output p1_req, p1_address,
    output p2_req, p2_wren, p2_address, p2_to_mem,
    output p3_req, p3_wren, p3_address, p3_to_mem,
    output mem_ready, mem_offset,
    input  p1_ready, p2_ready, p3_ready, p_offset,
    input  mem_req, mem_wren, mem_address, mem_to_mem
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one SDRAM controller port between three requesters. Every
//   transaction is a fixed 4-word burst. In IDLE the arbiter latches one
//   winner. p3 wins by priority, but a starvation guard limits it to
//   STARVE_LIMIT consecutive grants while p1 or p2 is waiting. p1 and p2
//   alternate through a round-robin slot. The arbiter holds the winner's
//   address and write flag for the whole burst and routes the controller's
//   word strobe back to that winner only.
//   Ports:
//     clk  system clock
//     rst  synchronous, active-high reset
//     bus  requester and controller signals (slave view of
//          sdram_port_arbiter_if)
module sdram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int P3_ADDR_W    = 17,
  parameter int DATA_W       = 16,
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sdram_port_arbiter_if.slave   bus
);
  localparam int         SC_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] LAST_OFF = 2'(BURST_LEN - 1);
  localparam logic       RR_P1    = 1'b0;
  localparam logic       RR_P2    = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;
  typedef enum logic [1:0] {G_NONE = 2'd0, G_P1 = 2'd1, G_P2 = 2'd2, G_P3 = 2'd3} grant_t;

  state_t            state, state_d;
  grant_t            grant, grant_d;
  logic [ADDR_W-1:0] mem_address_q, addr_d;
  logic              mem_wren_q, wren_d;
  logic [SC_W-1:0]   starve_cnt, starve_d;
  logic              rr_last, rr_d;

  logic p12_req, starve_full, p3_win, pick_p2;

  assign p12_req     = bus.p1_req | bus.p2_req;
  assign starve_full = (starve_cnt == SC_W'(STARVE_LIMIT));
  // p3 loses its priority only when it has used up its run AND someone else is waiting
  assign p3_win      = bus.p3_req & ~(starve_full & p12_req);
  // p2 wins a p1/p2 tie only when p1 took the last shared slot
  assign pick_p2     = bus.p2_req & (~bus.p1_req | (rr_last == RR_P1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= G_NONE;
      mem_address_q <= '0;
      mem_wren_q    <= 1'b0;
      starve_cnt    <= '0;
      rr_last       <= RR_P1;
    end else begin
      state         <= state_d;
      grant         <= grant_d;
      mem_address_q <= addr_d;
      mem_wren_q    <= wren_d;
      starve_cnt    <= starve_d;
      rr_last       <= rr_d;
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    addr_d   = mem_address_q;
    wren_d   = mem_wren_q;
    starve_d = starve_cnt;
    rr_d     = rr_last;
    case (state)
      IDLE: begin
        if (p3_win) begin
          state_d = BUSY;
          grant_d = G_P3;
          addr_d  = {{(ADDR_W-P3_ADDR_W){1'b0}}, bus.p3_address};
          wren_d  = bus.p3_wren;
          if (p12_req && !starve_full) starve_d = starve_cnt + 1'b1;
        end else if (p12_req) begin
          state_d  = BUSY;
          starve_d = '0;
          if (pick_p2) begin
            grant_d = G_P2;
            addr_d  = bus.p2_address;
            wren_d  = bus.p2_wren;
          end else begin
            grant_d = G_P1;
            addr_d  = bus.p1_address;
            wren_d  = 1'b0;
          end
          if (bus.p1_req && bus.p2_req) rr_d = pick_p2 ? RR_P2 : RR_P1;
        end
      end
      BUSY: begin
        // The controller cannot abort, so a dropped req does not end the burst.
        // Only the final word ends it.
        if (bus.mem_ready && bus.mem_offset == LAST_OFF) begin
          state_d = GAP;
          grant_d = G_NONE;
        end
      end
      GAP:     state_d = IDLE;  // gives the finished requester one cycle to drop req
      default: state_d = IDLE;
    endcase
  end

  logic              busy;
  logic [DATA_W-1:0] wdata;

  assign busy = (state == BUSY);

  always_comb begin
    wdata = '0;
    case (grant)
      G_P2:    wdata = bus.p2_to_mem;
      G_P3:    wdata = bus.p3_to_mem;
      default: wdata = '0;
    endcase
  end

  // The grant is one value, so the three readies are one-hot or all zero
  assign bus.p1_ready    = busy & (grant == G_P1) & bus.mem_ready;
  assign bus.p2_ready    = busy & (grant == G_P2) & bus.mem_ready;
  assign bus.p3_ready    = busy & (grant == G_P3) & bus.mem_ready;
  assign bus.p_offset    = bus.mem_offset;
  assign bus.mem_req     = busy;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_to_mem  = wdata;
endmodule
